trp_job_sched: RTL and testbench
================================

Name: trp_job_sched

Overview:
- Job scheduler in front of `transposer`: queues transpose jobs from NREQ requesters, arbitrates round-robin, and sequences the transposer one job at a time.
- For each job: selects the job's descriptor, issues `init_pulse`, waits for `finish` or a watchdog timeout, then returns a completion to the owning requester.
- Descriptor storage (the base, size and stride sets) lives in an external config table indexed by `cfg_sel`.

Parameters:
- NREQ, 2, number of requesters (2..4).
- JW, 4, job-id width; a job id indexes the descriptor table.
- QD, 4, per-requester queue depth (power of 2).
- TOW, 20, watchdog counter width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- req_vld  in  NREQ  per-requester job submit valid.
- req_job  in  NREQ*JW  per-requester job id; slice i belongs to requester i.
- req_rdy  out  NREQ  per-requester queue not full; a push occurs on req_vld[i] & req_rdy[i].
- timeout_cycles  in  TOW  watchdog limit in cycles; 0 disables the watchdog; sampled on RUN entry.
- cfg_sel  out  JW  descriptor-table index driven into the transposer config mux.
- cfg_owner  out  clog2(NREQ)  requester owning the current job.
- trp_init_pulse  out  1  to transposer `init_pulse`.
- trp_finish  in  1  from transposer `finish`.
- done_vld  out  NREQ  one-hot completion pulse, 1 cycle.
- done_job  out  JW  job id of the completed job.
- done_err  out  1  completion was caused by timeout.
- busy  out  1  state != IDLE or any queue non-empty.

Behaviour:
- **Reset values:** async clear of all state. req_rdy = all ones (queues empty). All other outputs 0. FSM = IDLE. rr_ptr = NREQ-1, so requester 0 wins first.

- **Queues:** one FIFO per requester, depth QD, width JW.
  - req_rdy[i] = ~full[i], computed from registered occupancy only; there is no bypass when full.
  - A push and a pop on the same queue in the same cycle are legal when not full; occupancy is unchanged.
  - Pushes are accepted in every FSM state.

- **FSM states:** IDLE, SETUP, LAUNCH, RUN, DONE.
  - **IDLE:** if any queue is non-empty, grant the first non-empty queue searching from rr_ptr+1 upward with wrap. Then pop it, latch cfg_sel <= head, latch cfg_owner <= grant, set rr_ptr <= grant, and go to SETUP. Otherwise stay in IDLE.
  - **SETUP:** one cycle with cfg_sel stable so the descriptor mux settles. Go to LAUNCH.
  - **LAUNCH:** trp_init_pulse = 1 for exactly this cycle (registered output). Load wd_cnt <= 0 and latch the timeout limit. Go to RUN.
  - **RUN:** wd_cnt increments each cycle.
    - If trp_finish: go to DONE with err = 0.
    - Else if limit != 0 and wd_cnt == limit-1: go to DONE with err = 1. RUN therefore lasts at most `limit` cycles.
    - If finish and timeout coincide, finish wins (err = 0).
  - **DONE:** done_vld[cfg_owner] = 1, done_job = cfg_sel, done_err = err, all for this cycle only. Go to IDLE.

- **Output stability:**
  - cfg_sel and cfg_owner are held from SETUP through DONE and keep their last values in IDLE.
  - done_job and done_err are valid only while done_vld is high and read 0 otherwise.

- **Latency:**
  - Push at edge T into empty queues with the FSM in IDLE gives SETUP in cycle T+2 and trp_init_pulse in cycle T+3.
  - trp_finish in cycle F gives done_vld in cycle F+1.
  - Minimum gap between consecutive init pulses = RUN length + 4 cycles.

- **Boundaries:**
  - trp_finish outside RUN is ignored; nothing is flagged.
  - A timed-out job is not retried. The transposer is not stopped; the next job's init_pulse restarts it.
  - Arbitration starvation is impossible: rr_ptr rotates on every grant.
  - Async reset mid-operation aborts the job silently: no done_vld, and queue contents are lost.

Test Plan:
1. Single job: req0 job 5 pushed at cycle 0, timeout_cycles = 0 -> cfg_sel = 5 from cycle 2, trp_init_pulse high only in cycle 3; trp_finish at cycle 10 -> cycle 11 done_vld = 01, done_job = 5, done_err = 0, busy falls in cycle 12.
2. Fairness: req0 pushes {1,2} and req1 pushes {8,9} at cycles 0 and 1 -> init order 1, 8, 2, 9; done_vld alternates 01, 10, 01, 10.
3. Full queue: while job 1 runs (no finish), req0 pushes jobs 2..5 -> req_rdy[0] drops after the 4th push; a 5th req_vld is not accepted. After job 1's DONE, the IDLE grant pops job 2 and req_rdy[0] rises the following cycle.
4. Timeout: timeout_cycles = 16, no finish -> RUN lasts exactly 16 cycles, then done_err = 1 with correct done_job; the next queued job launches 3 cycles after DONE.
5. Coincidence and spurious finish: finish in the cycle wd_cnt == limit-1 -> done_err = 0; trp_finish pulsed in IDLE -> no done_vld, no state change.
6. Reset mid-RUN: assert reset_n low during RUN with 2 jobs queued -> next edge shows all outputs at reset values, req_rdy all ones, busy = 0; no done_vld appears after release.

Source files
------------

// File: rtl/trp_job_sched.sv
// Round-robin job scheduler that queues transpose jobs per requester and sequences the
// transposer one job at a time with a watchdog.
module trp_job_sched #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned JW   = 4,
  parameter int unsigned QD   = 4,
  parameter int unsigned TOW  = 20,
  localparam int unsigned OW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NREQ-1:0]    req_vld,
  input  logic [NREQ*JW-1:0] req_job,
  output logic [NREQ-1:0]    req_rdy,
  input  logic [TOW-1:0]     timeout_cycles,
  output logic [JW-1:0]      cfg_sel,
  output logic [OW-1:0]      cfg_owner,
  output logic               trp_init_pulse,
  input  logic               trp_finish,
  output logic [NREQ-1:0]    done_vld,
  output logic [JW-1:0]      done_job,
  output logic               done_err,
  output logic               busy
);
  localparam int unsigned AW = $clog2(QD);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {StIdle, StSetup, StLaunch, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [OW-1:0]   rr_q, rr_d;
  logic [JW-1:0]   mem_q  [NREQ][QD];
  logic [JW-1:0]   mem_d  [NREQ][QD];
  logic [AW-1:0]   wptr_q [NREQ];
  logic [AW-1:0]   wptr_d [NREQ];
  logic [AW-1:0]   rptr_q [NREQ];
  logic [AW-1:0]   rptr_d [NREQ];
  logic [CW-1:0]   cnt_q  [NREQ];
  logic [CW-1:0]   cnt_d  [NREQ];
  logic [JW-1:0]   cfg_sel_q, cfg_sel_d;
  logic [OW-1:0]   cfg_owner_q, cfg_owner_d;
  logic            init_q, init_d;
  logic [TOW-1:0]  wd_q, wd_d;
  logic [TOW-1:0]  lim_q, lim_d;
  logic [NREQ-1:0] done_vld_q, done_vld_d;
  logic [JW-1:0]   done_job_q, done_job_d;
  logic            done_err_q, done_err_d;

  logic [NREQ-1:0] nempty, push, pop;
  logic            found;
  logic [OW-1:0]   gnt, idx;
  logic [JW-1:0]   head;

  // Occupancy comes from registers only, so a full queue never accepts a same-cycle push.
  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      nempty[i]  = (cnt_q[i] != '0);
      req_rdy[i] = (cnt_q[i] != CW'(QD));
      push[i]    = req_vld[i] & (cnt_q[i] != CW'(QD));
    end
  end

  // First non-empty queue after the last grant, with wrap.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    idx   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = OW'((32'(rr_q) + k) % NREQ);
      if (!found && nempty[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
    head = mem_q[gnt][rptr_q[gnt]];
    pop  = '0;
    if (state_q == StIdle && found) pop[gnt] = 1'b1;
  end

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (push[i]) begin
        mem_d[i][wptr_q[i]] = req_job[i*JW +: JW];
        wptr_d[i]           = wptr_q[i] + AW'(1);
      end
      if (pop[i]) rptr_d[i] = rptr_q[i] + AW'(1);
      cnt_d[i] = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    cfg_sel_d   = cfg_sel_q;
    cfg_owner_d = cfg_owner_q;
    init_d      = 1'b0;
    wd_d        = wd_q;
    lim_d       = lim_q;
    done_vld_d  = '0;
    done_job_d  = '0;
    done_err_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          cfg_sel_d   = head;
          cfg_owner_d = gnt;
          rr_d        = gnt;
          state_d     = StSetup;
        end
      end
      StSetup: begin
        init_d  = 1'b1;
        state_d = StLaunch;
      end
      StLaunch: begin
        wd_d    = '0;
        lim_d   = timeout_cycles;
        state_d = StRun;
      end
      StRun: begin
        wd_d = wd_q + TOW'(1);
        // Finish takes priority over a coincident watchdog expiry.
        if (trp_finish || (lim_q != '0 && wd_q == lim_q - TOW'(1))) begin
          state_d                 = StDone;
          done_vld_d[cfg_owner_q] = 1'b1;
          done_job_d              = cfg_sel_q;
          done_err_d              = ~trp_finish;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      rr_q        <= OW'(NREQ - 1);
      cfg_sel_q   <= '0;
      cfg_owner_q <= '0;
      init_q      <= 1'b0;
      wd_q        <= '0;
      lim_q       <= '0;
      done_vld_q  <= '0;
      done_job_q  <= '0;
      done_err_q  <= 1'b0;
      for (int unsigned i = 0; i < NREQ; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
        for (int unsigned j = 0; j < QD; j++) mem_q[i][j] <= '0;
      end
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      cfg_sel_q   <= cfg_sel_d;
      cfg_owner_q <= cfg_owner_d;
      init_q      <= init_d;
      wd_q        <= wd_d;
      lim_q       <= lim_d;
      done_vld_q  <= done_vld_d;
      done_job_q  <= done_job_d;
      done_err_q  <= done_err_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
      mem_q       <= mem_d;
    end
  end

  assign cfg_sel        = cfg_sel_q;
  assign cfg_owner      = cfg_owner_q;
  assign trp_init_pulse = init_q;
  assign done_vld       = done_vld_q;
  assign done_job       = done_job_q;
  assign done_err       = done_err_q;
  assign busy           = (state_q != StIdle) | (|nempty);

endmodule

// File: tb/tb_trp_job_sched.sv
// Directed scenarios plus a randomized job stream checked against a queue-level model of
// round-robin service, watchdog outcome and completion routing.
module tb_trp_job_sched;
  localparam int unsigned NREQ = 2;
  localparam int unsigned JW   = 4;
  localparam int unsigned QD   = 4;
  localparam int unsigned TOW  = 20;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [NREQ-1:0]    req_vld;
  logic [NREQ*JW-1:0] req_job;
  logic [NREQ-1:0]    req_rdy;
  logic [TOW-1:0]     timeout_cycles;
  logic [JW-1:0]      cfg_sel;
  logic [0:0]         cfg_owner;
  logic               trp_init_pulse;
  logic               trp_finish;
  logic [NREQ-1:0]    done_vld;
  logic [JW-1:0]      done_job;
  logic               done_err;
  logic               busy;

  trp_job_sched #(.NREQ(NREQ), .JW(JW), .QD(QD), .TOW(TOW)) dut (
    .clk(clk), .reset_n(reset_n), .req_vld(req_vld), .req_job(req_job), .req_rdy(req_rdy),
    .timeout_cycles(timeout_cycles), .cfg_sel(cfg_sel), .cfg_owner(cfg_owner),
    .trp_init_pulse(trp_init_pulse), .trp_finish(trp_finish), .done_vld(done_vld),
    .done_job(done_job), .done_err(done_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int mq[NREQ][$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Cycle n is the window just after rising edge n; inputs set here are captured at edge n+1.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (!trp_init_pulse && n < 60) begin
      step();
      n++;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rdy"}, 32'(req_rdy), 32'({NREQ{1'b1}}));
    chk({tag, "_sel"}, 32'(cfg_sel), 0);
    chk({tag, "_own"}, 32'(cfg_owner), 0);
    chk({tag, "_init"}, 32'(trp_init_pulse), 0);
    chk({tag, "_dvld"}, 32'(done_vld), 0);
    chk({tag, "_djob"}, 32'(done_job), 0);
    chk({tag, "_derr"}, 32'(done_err), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req_vld = '0;
    req_job = '0;
    trp_finish = 1'b0;
    timeout_cycles = '0;
    #3;
    chk_reset_vals("rst");
    step();
    reset_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    int n, g, lim, d, runlen, jb, total, last_g, exp_job;
    bit err;
    int t2_job[4];
    int t2_own[4];
    t2_job = '{1, 8, 2, 9};
    t2_own = '{1, 2, 1, 2};

    // Single job with spec latencies.
    do_reset();
    req_vld = 2'b01; req_job = 8'h05;
    step(); req_vld = '0;
    chk("t1_busy_c1", 32'(busy), 1);
    step();
    chk("t1_sel_c2", 32'(cfg_sel), 5);
    chk("t1_init_c2", 32'(trp_init_pulse), 0);
    step();
    chk("t1_init_c3", 32'(trp_init_pulse), 1);
    step();
    chk("t1_init_c4", 32'(trp_init_pulse), 0);
    run_to(10); trp_finish = 1'b1;
    step(); trp_finish = 1'b0;
    chk("t1_dvld", 32'(done_vld), 1);
    chk("t1_djob", 32'(done_job), 5);
    chk("t1_derr", 32'(done_err), 0);
    chk("t1_busy_c11", 32'(busy), 1);
    step();
    chk("t1_busy_c12", 32'(busy), 0);
    chk("t1_dvld_c12", 32'(done_vld), 0);
    chk("t1_djob_c12", 32'(done_job), 0);
    chk("t1_sel_hold", 32'(cfg_sel), 5);

    // Fairness between two requesters.
    do_reset();
    req_vld = 2'b11; req_job = {4'd8, 4'd1};
    step();
    req_job = {4'd9, 4'd2};
    step(); req_vld = '0;
    for (int k = 0; k < 4; k++) begin
      wait_init(n);
      chk("t2_init", 32'(trp_init_pulse), 1);
      chk("t2_sel", 32'(cfg_sel), 32'(t2_job[k]));
      step(); trp_finish = 1'b1;
      step(); trp_finish = 1'b0;
      chk("t2_dvld", 32'(done_vld), 32'(t2_own[k]));
      chk("t2_djob", 32'(done_job), 32'(t2_job[k]));
    end

    // Full queue back-pressure.
    do_reset();
    req_vld = 2'b01; req_job = 8'h01;
    step(); req_vld = '0;
    wait_init(n);
    chk("t3_init_c3", 32'(cyc), 3);
    for (int j = 2; j <= 5; j++) begin
      chk("t3_rdy_open", 32'(req_rdy[0]), 1);
      req_vld = 2'b01; req_job = 8'(j);
      step();
    end
    chk("t3_rdy_full", 32'(req_rdy[0]), 0);
    req_job = 8'h06;
    step();
    chk("t3_rdy_held", 32'(req_rdy[0]), 0);
    trp_finish = 1'b1;
    step(); trp_finish = 1'b0; req_vld = '0;
    chk("t3_dvld", 32'(done_vld), 1);
    chk("t3_djob", 32'(done_job), 1);
    step();
    chk("t3_rdy_idle", 32'(req_rdy[0]), 0);
    step();
    chk("t3_rdy_rise", 32'(req_rdy[0]), 1);
    chk("t3_sel_setup", 32'(cfg_sel), 2);
    for (int j = 2; j <= 5; j++) begin
      wait_init(n);
      chk("t3_sel", 32'(cfg_sel), 32'(j));
      step(); trp_finish = 1'b1;
      step(); trp_finish = 1'b0;
      chk("t3_drain_job", 32'(done_job), 32'(j));
    end
    wait_init(n);
    chk("t3_no_extra", 32'(trp_init_pulse), 0);
    chk("t3_busy_end", 32'(busy), 0);

    // Watchdog timeout, then coincident finish/timeout and a spurious finish.
    do_reset();
    timeout_cycles = 20'd16;
    req_vld = 2'b11; req_job = {4'd3, 4'd7};
    step(); req_vld = '0;
    wait_init(n);
    chk("t4_init_c3", 32'(cyc), 3);
    chk("t4_sel", 32'(cfg_sel), 7);
    step();
    for (int r = 0; r < 16; r++) begin
      chk("t4_run_quiet", 32'(done_vld), 0);
      step();
    end
    chk("t4_dvld", 32'(done_vld), 1);
    chk("t4_djob", 32'(done_job), 7);
    chk("t4_derr", 32'(done_err), 1);
    wait_init(n);
    chk("t4_gap", 32'(n), 3);
    chk("t4_sel2", 32'(cfg_sel), 3);
    chk("t4_own2", 32'(cfg_owner), 1);
    run_to(39); trp_finish = 1'b1;
    step(); trp_finish = 1'b0;
    chk("t5_dvld", 32'(done_vld), 2);
    chk("t5_djob", 32'(done_job), 3);
    chk("t5_derr", 32'(done_err), 0);
    step(); trp_finish = 1'b1;
    step(); trp_finish = 1'b0;
    chk("t5_spur_dvld", 32'(done_vld), 0);
    chk("t5_spur_init", 32'(trp_init_pulse), 0);
    chk("t5_spur_busy", 32'(busy), 0);
    step();
    chk("t5_spur_dvld2", 32'(done_vld), 0);
    chk("t5_sel_kept", 32'(cfg_sel), 3);

    // Reset in the middle of RUN with jobs still queued.
    do_reset();
    req_vld = 2'b11; req_job = {4'd2, 4'd1};
    step();
    req_vld = 2'b01; req_job = 8'h03;
    step(); req_vld = '0;
    wait_init(n);
    step();
    #2 reset_n = 1'b0;
    step();
    chk_reset_vals("t6");
    reset_n = 1'b1;
    for (int r = 0; r < 30; r++) begin
      step();
      chk("t6_no_done", 32'(done_vld), 0);
      chk("t6_no_init", 32'(trp_init_pulse), 0);
    end

    // Randomized stream against the queue-level model.
    do_reset();
    last_g = NREQ - 1;
    for (int it = 0; it < 40; it++) begin
      total = 0;
      for (int i = 0; i < NREQ; i++) total += mq[i].size();
      if (total == 0) begin
        g = $urandom_range(0, NREQ - 1);
        jb = $urandom_range(0, 15);
        chk("rnd_rdy_empty", 32'(req_rdy[g]), 1);
        req_vld[g] = 1'b1;
        req_job[g*JW +: JW] = JW'(jb);
        mq[g].push_back(jb);
      end
      lim = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 10);
      d = $urandom_range(0, 12);
      err = (lim != 0) && (d >= lim);
      runlen = err ? lim : d + 1;
      timeout_cycles = TOW'(lim);
      step(); req_vld = '0;
      wait_init(n);
      chk("rnd_launch_gap", 32'(n), 2);
      g = -1;
      for (int k = 1; k <= NREQ; k++)
        if (g < 0 && mq[(last_g + k) % NREQ].size() > 0) g = (last_g + k) % NREQ;
      last_g = g;
      exp_job = mq[g].pop_front();
      chk("rnd_sel", 32'(cfg_sel), 32'(exp_job));
      chk("rnd_own", 32'(cfg_owner), 32'(g));
      step();
      for (int r = 0; r < runlen; r++) begin
        trp_finish = (r == d);
        for (int i = 0; i < NREQ; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            jb = $urandom_range(0, 15);
            chk("rnd_rdy", 32'(req_rdy[i]), 32'(mq[i].size() < QD));
            req_vld[i] = 1'b1;
            req_job[i*JW +: JW] = JW'(jb);
            if (mq[i].size() < QD) mq[i].push_back(jb);
          end
        end
        chk("rnd_run_quiet", 32'(done_vld), 0);
        step();
        req_vld = '0;
        trp_finish = 1'b0;
      end
      chk("rnd_dvld", 32'(done_vld), 32'(1 << g));
      chk("rnd_djob", 32'(done_job), 32'(exp_job));
      chk("rnd_derr", 32'(done_err), 32'(err));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
